// File: rtl/pmod_input_conditioner_pkg.sv
// rtl/pmod_input_conditioner_pkg.sv - shared constants for the PMOD input conditioner
package pmod_pkg;

   localparam int PMOD_WIDTH     = 8;
   localparam int OPERAND_WIDTH  = 4;
   localparam int DEFAULT_CLK_HZ = 12000000;

   // op_a takes PMOD1..PMOD4, op_b takes PMOD7..PMOD10
   localparam int OP_A_LSB = 0;
   localparam int OP_A_MSB = OP_A_LSB + OPERAND_WIDTH - 1;
   localparam int OP_B_LSB = OPERAND_WIDTH;
   localparam int OP_B_MSB = OP_B_LSB + OPERAND_WIDTH - 1;

   typedef logic [OPERAND_WIDTH-1:0] operand_t;

endpackage

// File: rtl/pmod_input_conditioner_debounce_bit.sv
// rtl/pmod_input_conditioner_debounce_bit.sv - per-pin synchroniser, debounce counter and edge pulses
module debounce_bit
   import pmod_pkg::*;
#(
   parameter int STABLE_SAMPLES = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   input  logic tick,
   output logic clean,
   output logic rise,
   output logic fall
);

   localparam int            CW   = $clog2(STABLE_SAMPLES + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE_SAMPLES - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt;
   logic          sync_bit;
   logic          accept;

   assign sync_bit = sync_q[1];
   assign accept   = tick && (sync_bit != clean) && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt    <= '0;
         clean  <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], din};
         rise   <= accept && sync_bit;
         fall   <= accept && !sync_bit;
         // any sample agreeing with the current level abandons a pending change
         if (tick) begin
            if (sync_bit == clean) begin
               cnt <= '0;
            end else if (cnt == LAST) begin
               clean <= sync_bit;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pmod_input_conditioner.sv
// rtl/pmod_input_conditioner.sv - synchronise, debounce and split the 8 PMOD switch pins into adder operands
module pmod_input_conditioner
   import pmod_pkg::*;
#(
   parameter int CLK_HZ         = DEFAULT_CLK_HZ,
   parameter int SAMPLE_HZ      = 1000,
   parameter int STABLE_SAMPLES = 8,
   parameter int WIDTH          = PMOD_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         pmod_in,
   output logic [WIDTH-1:0]         clean,
   output logic [OPERAND_WIDTH-1:0] op_a,
   output logic [OPERAND_WIDTH-1:0] op_b,
   output logic [WIDTH-1:0]         rise,
   output logic [WIDTH-1:0]         fall,
   output logic                     update,
   output logic                     sample_tick
);

   localparam int            DIV      = CLK_HZ / SAMPLE_HZ;
   localparam int            PW       = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] CNT_LAST = PW'(DIV - 1);
   localparam logic [PW-1:0] CNT_PRE  = PW'(DIV - 2);

   if (DIV < 2 || STABLE_SAMPLES < 1 || WIDTH != PMOD_WIDTH) begin : g_param_error
      $error("pmod_input_conditioner: need DIV>=2, STABLE_SAMPLES>=1, WIDTH==8");
   end

   logic [PW-1:0] count;

   // tick is registered one count early so it is high exactly while count==DIV-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count       <= '0;
         sample_tick <= 1'b0;
      end else begin
         count       <= (count == CNT_LAST) ? '0 : count + 1'b1;
         sample_tick <= (count == CNT_PRE);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .STABLE_SAMPLES(STABLE_SAMPLES)
      ) u_debounce (
         .clk  (clk),
         .rst_n(rst_n),
         .din  (pmod_in[i]),
         .tick (sample_tick),
         .clean(clean[i]),
         .rise (rise[i]),
         .fall (fall[i])
      );
   end

   // OR of the registered edge flops, so it shares their timing exactly
   assign update = (|rise) | (|fall);

   assign op_a = clean[OP_A_MSB:OP_A_LSB];
   assign op_b = clean[OP_B_MSB:OP_B_LSB];

endmodule

// File: tb/tb_pmod_input_conditioner.sv
// tb/tb_pmod_input_conditioner.sv - directed self-checking bench for pmod_input_conditioner
module tb_pmod_input_conditioner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] pmod_in;
   logic [7:0] clean, rise, fall;
   logic [3:0] op_a, op_b;
   logic       update, sample_tick;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         upd_cnt = 0;
   logic [7:0] rise_acc = '0;
   logic [7:0] fall_acc = '0;
   logic [39:0] tick_obs, tick_exp;

   pmod_input_conditioner #(
      .CLK_HZ(100), .SAMPLE_HZ(10), .STABLE_SAMPLES(3), .WIDTH(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pmod_in(pmod_in), .clean(clean), .op_a(op_a), .op_b(op_b),
      .rise(rise), .fall(fall), .update(update), .sample_tick(sample_tick)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (update) upd_cnt++;
      rise_acc |= rise;
      fall_acc |= fall;
   endtask

   task automatic step_to(input int target);
      while (cyc < target) step();
   endtask

   initial begin
      rst_n   = 1'b0;
      pmod_in = 8'hFF;
      repeat (3) step();
      check_eq("reset_outputs", 64'({clean, rise, fall, update, sample_tick, op_a, op_b}), 64'd0);

      // run-in with all pins high through release; tick first after edge 9
      rst_n = 1'b1; cyc = 0; upd_cnt = 0;
      for (int n = 1; n <= 40; n++) begin
         step();
         tick_obs[n-1] = sample_tick;
         tick_exp[n-1] = (n % 10 == 9);
         if (n == 29) check_eq("runin_clean_before", 64'(clean), 64'h00);
         if (n == 30) begin
            check_eq("runin_clean", 64'(clean), 64'hFF);
            check_eq("runin_rise", 64'(rise), 64'hFF);
            check_eq("runin_update", 64'(update), 64'd1);
         end
         if (n == 31) check_eq("runin_pulse_end", 64'({rise, update}), 64'd0);
      end
      check_eq("tick_pattern", 64'(tick_obs), 64'(tick_exp));
      check_eq("runin_updates", 64'(upd_cnt), 64'd1);

      // asynchronous reset mid-cycle
      #3 rst_n = 1'b0;
      #1 check_eq("async_reset_outputs", 64'({clean, rise, fall, update, sample_tick, op_a, op_b}), 64'd0);
      pmod_in = 8'h00;
      step(); step();
      rst_n = 1'b1; cyc = 0; upd_cnt = 0; rise_acc = '0; fall_acc = '0;

      // single step on bit 0: sync at 17, ticks at 20/30/40
      step_to(15); pmod_in = 8'h01;
      step_to(39); check_eq("step_clean_before", 64'(clean), 64'h00);
      step();
      check_eq("step_clean", 64'(clean), 64'h01);
      check_eq("step_op_a", 64'(op_a), 64'h1);
      check_eq("step_rise", 64'(rise), 64'h01);
      check_eq("step_update", 64'(update), 64'd1);
      step();
      check_eq("step_pulse_end", 64'({rise, update}), 64'd0);
      check_eq("step_updates", 64'(upd_cnt), 64'd1);

      // glitch on bit 5 seen on ticks 50 and 60 only
      upd_cnt = 0; rise_acc = '0;
      step_to(45); pmod_in = 8'h21;
      step_to(65); pmod_in = 8'h01;
      step_to(100);
      check_eq("glitch_clean", 64'(clean), 64'h01);
      check_eq("glitch_updates", 64'(upd_cnt), 64'd0);
      check_eq("glitch_rise", 64'(rise_acc), 64'h00);

      step_to(105); pmod_in = 8'h00;
      step_to(130);
      check_eq("rel0_fall", 64'(fall), 64'h01);
      check_eq("rel0_clean", 64'(clean), 64'h00);

      // multi-bit acceptance
      upd_cnt = 0;
      step_to(135); pmod_in = 8'hA5;
      step_to(159); check_eq("multi_clean_before", 64'(clean), 64'h00);
      step();
      check_eq("multi_op_a", 64'(op_a), 64'h5);
      check_eq("multi_op_b", 64'(op_b), 64'hA);
      check_eq("multi_rise", 64'(rise), 64'hA5);
      check_eq("multi_update", 64'(update), 64'd1);
      step_to(175);
      check_eq("multi_updates", 64'(upd_cnt), 64'd1);

      pmod_in = 8'h00;
      step_to(199); check_eq("rel_clean_before", 64'(clean), 64'hA5);
      step();
      check_eq("rel_fall", 64'(fall), 64'hA5);
      check_eq("rel_clean", 64'(clean), 64'h00);
      step();
      check_eq("rel_fall_end", 64'(fall), 64'h00);

      // release aborted by reset after two ticks
      step_to(205); pmod_in = 8'hA5;
      step_to(230); check_eq("abort_setup_clean", 64'(clean), 64'hA5);
      step_to(235); pmod_in = 8'h00; fall_acc = '0; upd_cnt = 0;
      step_to(255);
      rst_n = 1'b0;
      #1 check_eq("abort_reset_clean", 64'(clean), 64'h00);
      step(); step();
      rst_n = 1'b1; cyc = 0;
      step_to(40);
      check_eq("abort_fall_acc", 64'(fall_acc), 64'h00);
      check_eq("abort_updates", 64'(upd_cnt), 64'd0);
      check_eq("abort_clean", 64'(clean), 64'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
